i2c_master_ctrl: RTL and testbench

Command-driven I2C master controller that sequences the shared open-drain SDA/SCL bus. It generates START, address, data and ACK bits and STOP for one requester through a valid/ready command port. Write bytes are pulled and read bytes are pushed one at a time. It sits between the system-side register/DMA logic and the board-level open-drain pads: `scl_oe`/`sda_oe` drive the pad low and `scl_i`/`sda_i` read the resolved wired-AND line.

---
 rtl/i2c_master_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_ctrl.sv
// Purpose: command-driven I2C master; sequences START, address, data/ACK bits and STOP on open-drain SCL/SDA pads.
// Latency: START + 9 bits per byte (address included) + STOP at 4*CLK_DIV cycles per bit; done pulses the cycle after STOP.
// Backpressure: cmd_ready low while a transaction runs; write/read bytes move by 1-cycle pulses; the target may stretch SCL.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [3:0] cmd_len,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       nack,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);
    localparam int QW = 10;
    localparam logic [QW-1:0] Q_LAST = QW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] qcnt;
    logic [1:0]    qtr;
    logic [2:0]    bitcnt;
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          rw_q;
    logic [3:0]    rem;      // data bytes still to go, counting the current one
    logic          ack_smp;  // SDA level sampled during the current bit's SCL-high phase
    logic          nack_q;
    logic          armed;    // low during reset so handshake outputs stay quiet until released

    logic accept, timed, bit_state, stall, q_tick, bit_end, sample;

    assign accept    = cmd_valid && cmd_ready;
    assign timed     = (state != S_IDLE) && (state != S_DONE);
    assign bit_state = (state == S_ADDR) || (state == S_ADDR_ACK) || (state == S_WR_BYTE) ||
                       (state == S_WR_ACK) || (state == S_RD_BYTE) || (state == S_RD_ACK);
    // Quarters where SCL has been released: hold the count until the line actually reads high.
    assign stall     = !scl_i && ((bit_state && qtr == 2'd1) ||
                                  (state == S_START && qtr == 2'd0) ||
                                  (state == S_STOP && qtr == 2'd1));
    assign q_tick    = (qcnt == Q_LAST) && !stall;
    assign bit_end   = q_tick && (qtr == 2'd3);
    assign sample    = bit_state && (qtr == 2'd1) && q_tick;

    // Quarter-bit timebase; idle outside the bus-timed states.
    always_ff @(posedge clk) begin
        if (rst || !timed) begin
            qcnt <= '0;
            qtr  <= 2'd0;
        end else if (!stall) begin
            if (qcnt == Q_LAST) begin
                qcnt <= '0;
                qtr  <= qtr + 2'd1;
            end else begin
                qcnt <= qcnt + QW'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    // Next-state decode; every bit state advances on its last quarter.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_START;
            S_START:    if (bit_end) state_nxt = S_ADDR;
            S_ADDR:     if (bit_end && bitcnt == 3'd7) state_nxt = S_ADDR_ACK;
            S_ADDR_ACK: if (bit_end) begin
                            if (ack_smp || rem == 4'd0) state_nxt = S_STOP;
                            else if (rw_q)              state_nxt = S_RD_BYTE;
                            else                        state_nxt = S_WR_BYTE;
                        end
            S_WR_BYTE:  if (bit_end && bitcnt == 3'd7) state_nxt = S_WR_ACK;
            S_WR_ACK:   if (bit_end) state_nxt = (ack_smp || rem == 4'd1) ? S_STOP : S_WR_BYTE;
            S_RD_BYTE:  if (bit_end && bitcnt == 3'd7) state_nxt = S_RD_ACK;
            S_RD_ACK:   if (bit_end) state_nxt = (rem == 4'd1) ? S_STOP : S_RD_BYTE;
            S_STOP:     if (bit_end) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Command latch, shift registers, byte counting and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh    <= '0;
            rx_sh    <= '0;
            rw_q     <= 1'b0;
            rem      <= '0;
            bitcnt   <= '0;
            ack_smp  <= 1'b0;
            nack_q   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (accept) begin
                tx_sh  <= {cmd_addr, cmd_rw};
                rw_q   <= cmd_rw;
                rem    <= cmd_len;
                bitcnt <= '0;
                nack_q <= 1'b0;
            end else if (wr_ready) begin
                tx_sh <= wr_data;
            end else if (bit_end && (state == S_ADDR || state == S_WR_BYTE)) begin
                tx_sh <= {tx_sh[6:0], 1'b0};
            end
            if (bit_end && (state == S_ADDR || state == S_WR_BYTE || state == S_RD_BYTE))
                bitcnt <= bitcnt + 3'd1;
            if (sample) begin
                ack_smp <= sda_i;
                if (state == S_RD_BYTE)
                    rx_sh <= {rx_sh[6:0], sda_i};
            end
            if (state == S_RD_BYTE && state_nxt == S_RD_ACK) begin
                rd_valid <= 1'b1;
                rd_data  <= rx_sh;
            end
            if (bit_end && (state == S_ADDR_ACK || state == S_WR_ACK) && ack_smp)
                nack_q <= 1'b1;
            if (bit_end && (state == S_WR_ACK || state == S_RD_ACK))
                rem <= rem - 4'd1;
        end
    end

    // Pad and handshake outputs decoded from state and quarter.
    // The first q0 cycle of a write byte still shows the previous shift value on SDA;
    // SCL is low then, so the bus never sees it.
    always_comb begin
        scl_oe    = 1'b0;
        sda_oe    = 1'b0;
        cmd_ready = armed && (state == S_IDLE);
        busy      = armed && (state != S_IDLE);
        wr_ready  = (state == S_WR_BYTE) && (bitcnt == 3'd0) && (qtr == 2'd0) && (qcnt == '0);
        done      = (state == S_DONE);
        nack      = (state == S_DONE) && nack_q;
        case (state)
            S_START: begin
                sda_oe = (qtr != 2'd0);
                scl_oe = (qtr == 2'd3);
            end
            S_ADDR, S_WR_BYTE: begin
                scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
                sda_oe = !tx_sh[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: begin
                scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
            end
            S_RD_ACK: begin
                scl_oe = (qtr == 2'd0) || (qtr == 2'd3);
                sda_oe = (rem != 4'd1);
            end
            S_STOP: begin
                scl_oe = (qtr == 2'd0);
                sda_oe = (qtr <= 2'd1);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Purpose: self-checking bench for i2c_master_ctrl with a reactive I2C target model on a wired-AND bus.
// Latency: expected completion cycles come from the bit-count formula, not from the design.
// Backpressure: target ACK/NACK and SCL stretching are driven by the bench per scenario.
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 2;
    localparam int B = 4 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_addr;
    logic       cmd_rw;
    logic [3:0] cmd_len;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       nack;
    logic       busy;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_i;
    logic       sda_i;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .nack(nack), .busy(busy),
        .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
    );

    int checks = 0;
    int errors = 0;

    // Target configuration (written by the stimulus, read by the target model).
    logic [7:0] wr_bytes [16];
    logic [7:0] t_rd     [16];
    logic       t_ack_addr;
    int         t_nack_byte;   // 1-based data byte the target NACKs; 0 = none
    logic       stretch_req;

    // Target model state.
    logic       p_scl, p_sda, t_drive, in_x, is_rd, act_rd;
    logic [8:0] fr;
    int         bitn, byten, n_start = 0, n_stop = 0, stretch_left = 0, wr_idx = 0, wr_base = 0;
    logic [8:0] frames [$];

    assign scl_i   = !scl_oe && (stretch_left == 0);
    assign sda_i   = !sda_oe && !t_drive;
    assign wr_data = wr_bytes[4'(wr_idx - wr_base)];

    // Write-byte supply advances once per consumed byte.
    always @(posedge clk) wr_idx <= wr_idx + (wr_ready ? 1 : 0);

    // Behavioural I2C target: logs every 9-bit frame seen at SCL rise, answers ACKs, serves read data.
    always @(posedge clk) begin
        p_scl <= scl_i;
        p_sda <= sda_i;
        if (!scl_oe && stretch_left > 0) stretch_left <= stretch_left - 1;
        if (rst) begin
            in_x <= 1'b0; t_drive <= 1'b0; act_rd <= 1'b0; is_rd <= 1'b0; bitn <= 0; byten <= 0;
        end else if (p_scl && scl_i && p_sda && !sda_i) begin
            in_x <= 1'b1; bitn <= 0; byten <= 0; t_drive <= 1'b0; act_rd <= 1'b0;
            n_start <= n_start + 1;
        end else if (p_scl && scl_i && !p_sda && sda_i) begin
            in_x <= 1'b0; t_drive <= 1'b0;
            n_stop <= n_stop + 1;
        end else if (in_x && !p_scl && scl_i) begin
            fr <= {fr[7:0], sda_i};
            if (bitn == 8) begin
                frames.push_back({fr[7:0], sda_i});
                bitn  <= 0;
                byten <= byten + 1;
                if (byten == 0) act_rd <= is_rd && !sda_i;
                else if (is_rd && sda_i) act_rd <= 1'b0;
            end else begin
                bitn <= bitn + 1;
            end
            if (byten == 0 && bitn == 7) is_rd <= sda_i;
        end else if (in_x && p_scl && !scl_i) begin
            if (bitn == 8)
                t_drive <= (byten == 0) ? t_ack_addr : (!is_rd && byten != t_nack_byte);
            else if (act_rd && byten >= 1)
                t_drive <= !t_rd[byten-1][7-bitn];
            else
                t_drive <= 1'b0;
            if (stretch_req && byten == 0 && bitn == 3) stretch_left <= 20;
        end
    end

    // Reference model: expected frames, read bytes, byte count, nack and completion cycle.
    logic [8:0] exp_frames [$];
    logic [7:0] exp_rd     [$];
    int         exp_n, exp_done;
    logic       exp_nack;

    task automatic build_expect(input logic rw, input logic [6:0] a, input int len, input logic ack_a, input int nk);
        logic nb;
        exp_frames.delete();
        exp_rd.delete();
        exp_frames.push_back({a, rw, !ack_a});
        exp_n = 0;
        if (ack_a) begin
            for (int k = 1; k <= len; k++) begin
                exp_n = k;
                if (!rw) begin
                    nb = (k == nk);
                    exp_frames.push_back({wr_bytes[k-1], nb});
                    if (nb) break;
                end else begin
                    exp_frames.push_back({t_rd[k-1], k == len});
                    exp_rd.push_back(t_rd[k-1]);
                end
            end
        end
        exp_nack = !ack_a || (!rw && nk >= 1 && nk <= len);
        exp_done = (2 + 9 * (1 + exp_n)) * B + 1;
    endtask

    // Observations from one transaction.
    int         obs_done, obs_done_cnt, obs_wr, fr_base, st_base, sp_base;
    logic       obs_nack, obs_rdy_after;
    logic [7:0] rd_obs [$];

    task automatic issue_cmd(input logic [6:0] a, input logic rw, input logic [3:0] len);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
        fr_base = frames.size(); st_base = n_start; sp_base = n_stop; wr_base = wr_idx;
        cmd_addr = a; cmd_rw = rw; cmd_len = len; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr = 7'($urandom); cmd_len = 4'($urandom); cmd_rw = 1'($urandom);
    endtask

    // Runs one command to completion (bounded); relative cycle 1 is the cycle after acceptance.
    task automatic run_xfer(input logic [6:0] a, input logic rw, input logic [3:0] len, input int limit);
        int rel;
        issue_cmd(a, rw, len);
        rel = 1; obs_done = -1; obs_done_cnt = 0; obs_wr = 0; obs_nack = 1'bx; obs_rdy_after = 1'b0;
        rd_obs.delete();
        while (rel <= limit) begin
            if (wr_ready) obs_wr++;
            if (rd_valid) rd_obs.push_back(rd_data);
            if (obs_done >= 0 && rel == obs_done + 1) begin obs_rdy_after = cmd_ready; break; end
            if (done) begin
                if (obs_done < 0) begin obs_done = rel; obs_nack = nack; end
                obs_done_cnt++;
            end
            if (cmd_valid == 1'b0 && busy == cmd_ready) begin
                checks++; errors++;
                $display("FAIL busy_vs_ready cycle %0d busy %0b cmd_ready %0b", rel, busy, cmd_ready);
            end
            @(negedge clk);
            rel++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_len = '0;
        t_ack_addr = 1'b1; t_nack_byte = 0; stretch_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, scl_oe, sda_oe, wr_ready, rd_valid, done, nack, rd_data} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0000",
                     {cmd_ready, busy, scl_oe, sda_oe, wr_ready, rd_valid, done, nack, rd_data});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || scl_i !== 1'b1 || sda_i !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got rdy %b busy %b scl %b sda %b required 1 0 1 1",
                     cmd_ready, busy, scl_i, sda_i);
        end
    endtask

    task automatic test_write;
        wr_bytes[0] = 8'hA5; t_ack_addr = 1'b1; t_nack_byte = 0;
        build_expect(1'b0, 7'h50, 1, 1'b1, 0);
        run_xfer(7'h50, 1'b0, 4'd1, 400);
        checks++;
        if (obs_done !== 161 || obs_nack !== 1'b0 || obs_done_cnt !== 1) begin
            errors++; $display("FAIL write_done got cyc %0d nack %b cnt %0d required 161 0 1", obs_done, obs_nack, obs_done_cnt);
        end
        checks++;
        if (obs_wr !== 1 || obs_rdy_after !== 1'b1) begin
            errors++; $display("FAIL write_wr_ready got %0d rdy_after %b required 1 1", obs_wr, obs_rdy_after);
        end
        checks++;
        if (frames.size() - fr_base !== 2 || frames[fr_base] !== 9'h140 || frames[fr_base+1] !== 9'h14A) begin
            errors++; $display("FAIL write_bus got %0d frames first %h required 2 frames 140 14a", frames.size() - fr_base, frames[fr_base]);
        end
        checks++;
        if (n_start - st_base !== 1 || n_stop - sp_base !== 1) begin
            errors++; $display("FAIL write_start_stop got %0d/%0d required 1/1", n_start - st_base, n_stop - sp_base);
        end
    endtask

    task automatic test_addr_nack;
        t_ack_addr = 1'b0; t_nack_byte = 0;
        run_xfer(7'h21, 1'b0, 4'd3, 400);
        checks++;
        if (obs_done !== 89 || obs_nack !== 1'b1 || obs_wr !== 0) begin
            errors++; $display("FAIL addr_nack got cyc %0d nack %b wr %0d required 89 1 0", obs_done, obs_nack, obs_wr);
        end
        checks++;
        if (frames.size() - fr_base !== 1 || frames[fr_base] !== {7'h21, 1'b0, 1'b1}) begin
            errors++; $display("FAIL addr_nack_bus got %0d frames required 1", frames.size() - fr_base);
        end
        t_ack_addr = 1'b1;
    endtask

    task automatic test_read;
        t_rd[0] = 8'h12; t_rd[1] = 8'h34; t_ack_addr = 1'b1;
        build_expect(1'b1, 7'h3C, 2, 1'b1, 0);
        run_xfer(7'h3C, 1'b1, 4'd2, 400);
        checks++;
        if (obs_done !== 233 || obs_nack !== 1'b0) begin
            errors++; $display("FAIL read_done got cyc %0d nack %b required 233 0", obs_done, obs_nack);
        end
        checks++;
        if (rd_obs.size() !== 2 || rd_obs[0] !== 8'h12 || rd_obs[1] !== 8'h34) begin
            errors++; $display("FAIL read_data got %0d bytes first %h required 2 bytes 12 34", rd_obs.size(), rd_obs[0]);
        end
        checks++;
        if (frames.size() - fr_base !== 3 || frames[fr_base+1] !== 9'h024 || frames[fr_base+2] !== 9'h069) begin
            errors++; $display("FAIL read_master_ack got %0d frames required ack on byte1 nack on byte2", frames.size() - fr_base);
        end
    endtask

    task automatic test_stretch;
        wr_bytes[0] = 8'hA5; t_ack_addr = 1'b1; t_nack_byte = 0; stretch_req = 1'b1;
        run_xfer(7'h50, 1'b0, 4'd1, 400);
        stretch_req = 1'b0;
        checks++;
        if (obs_done !== 181 || obs_nack !== 1'b0) begin
            errors++; $display("FAIL stretch_done got cyc %0d nack %b required 181 0", obs_done, obs_nack);
        end
        checks++;
        if (frames.size() - fr_base !== 2 || frames[fr_base] !== 9'h140 || frames[fr_base+1] !== 9'h14A) begin
            errors++; $display("FAIL stretch_bus got %0d frames first %h required 140 14a", frames.size() - fr_base, frames[fr_base]);
        end
    endtask

    task automatic test_random;
        logic [6:0] a;
        logic       rw, ack_a;
        int         len, nk;
        for (int it = 0; it < 10; it++) begin
            a = 7'($urandom); rw = 1'($urandom); len = $urandom_range(0, 6);
            ack_a = ($urandom_range(0, 3) != 0);
            nk = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, len + 1);
            for (int k = 0; k < 16; k++) begin wr_bytes[k] = 8'($urandom); t_rd[k] = 8'($urandom); end
            t_ack_addr = ack_a; t_nack_byte = nk;
            build_expect(rw, a, len, ack_a, nk);
            run_xfer(a, rw, 4'(len), exp_done + 40);
            checks++;
            if (obs_done !== exp_done || obs_nack !== exp_nack || obs_done_cnt !== 1) begin
                errors++; $display("FAIL rand%0d_done got cyc %0d nack %b required %0d %b", it, obs_done, obs_nack, exp_done, exp_nack);
            end
            checks++;
            if (obs_wr !== (rw ? 0 : exp_n)) begin
                errors++; $display("FAIL rand%0d_wr_ready got %0d required %0d", it, obs_wr, rw ? 0 : exp_n);
            end
            checks++;
            if (rd_obs != exp_rd) begin
                errors++; $display("FAIL rand%0d_rd got %0d bytes required %0d", it, rd_obs.size(), exp_rd.size());
            end
            checks++;
            if (frames.size() - fr_base !== exp_frames.size()) begin
                errors++; $display("FAIL rand%0d_frames got %0d required %0d", it, frames.size() - fr_base, exp_frames.size());
            end else begin
                for (int i = 0; i < exp_frames.size(); i++) begin
                    checks++;
                    if (frames[fr_base+i] !== exp_frames[i]) begin
                        errors++; $display("FAIL rand%0d_frame%0d got %h required %h", it, i, frames[fr_base+i], exp_frames[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int w, dcnt;
        for (int k = 0; k < 4; k++) wr_bytes[k] = 8'h30 + 8'(k);
        t_ack_addr = 1'b1; t_nack_byte = 0;
        issue_cmd(7'h2A, 1'b0, 4'd3);
        w = 0;
        while (!wr_ready && w < 400) begin @(negedge clk); w++; end
        checks++;
        if (w >= 400) begin errors++; $display("FAIL reset_mid_reach_wr got timeout required wr_ready"); end
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_release got scl_oe %b sda_oe %b done %b required 0 0 0", scl_oe, sda_oe, done);
        end
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (4) begin @(negedge clk); if (done) dcnt++; end
        checks++;
        if (dcnt !== 0) begin errors++; $display("FAIL reset_mid_no_done got %0d required 0", dcnt); end
        build_expect(1'b0, 7'h2A, 2, 1'b1, 0);
        run_xfer(7'h2A, 1'b0, 4'd2, exp_done + 40);
        checks++;
        if (obs_done !== exp_done || obs_nack !== 1'b0 || obs_wr !== 2) begin
            errors++; $display("FAIL reset_mid_fresh got cyc %0d nack %b wr %0d required %0d 0 2", obs_done, obs_nack, obs_wr, exp_done);
        end
        checks++;
        if (frames.size() - fr_base !== 3 || frames[fr_base+2] !== {8'h31, 1'b0}) begin
            errors++; $display("FAIL reset_mid_bus got %0d frames required 3", frames.size() - fr_base);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_nack();
        test_read();
        test_stretch();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
